// File: rtl/execute_stage_pkg.sv
// Shared encodings and packed-word field map for the decode/execute and
// execute/memory pipeline registers.
package execute_stage_pkg;

   localparam int EX_IN_W  = 103;
   localparam int EX_OUT_W = 72;

   typedef enum logic [2:0] {
      ALU_AND   = 3'b000,
      ALU_OR    = 3'b001,
      ALU_ADD   = 3'b010,
      ALU_RSVD3 = 3'b011,
      ALU_RSVD4 = 3'b100,
      ALU_NOR   = 3'b101,
      ALU_SUB   = 3'b110,
      ALU_SLT   = 3'b111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_e;

   // Decode/execute word
   localparam int D_REGWRITE  = 102;
   localparam int D_MEMTOREG  = 101;
   localparam int D_MEMWRITE  = 100;
   localparam int D_ALUCTL_LO = 97;
   localparam int D_ALUSRC    = 96;
   localparam int D_REGDST    = 95;
   localparam int D_OP1_LO    = 63;
   localparam int D_OP2_LO    = 31;
   localparam int D_RS_LO     = 26;
   localparam int D_RT_LO     = 21;
   localparam int D_RD_LO     = 16;
   localparam int D_IMM_LO    = 0;

   // Execute/memory word
   localparam int E_REGWRITE  = 71;
   localparam int E_MEMTOREG  = 70;
   localparam int E_MEMWRITE  = 69;
   localparam int E_ALUOUT_LO = 37;
   localparam int E_WDATA_LO  = 5;
   localparam int E_WREG_LO   = 0;

endpackage

// File: rtl/execute_stage_alu_unit.sv
// Combinational ALU for the execute stage; also reports a zero result.
module alu_unit
   import execute_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] SrcA,
   input  logic [DATA_W-1:0] SrcB,
   input  logic [2:0]        ALUControl,
   output logic [DATA_W-1:0] Result,
   output logic              Zero
);

   // NOTE: combinational blocks assign a default first so no path can infer a latch.
   always_comb begin
      Result = '0;
      case (alu_ctrl_e'(ALUControl))
         ALU_ADD: Result = SrcA + SrcB;
         ALU_SUB: Result = SrcA - SrcB;
         ALU_AND: Result = SrcA & SrcB;
         ALU_OR:  Result = SrcA | SrcB;
         ALU_NOR: Result = ~(SrcA | SrcB);
         ALU_SLT: Result = {{(DATA_W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         default: Result = '0;
      endcase
   end

   assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute pipeline stage: operand forwarding, ALU, and the execute/memory
// output register with flush and stall control.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IN_W   = EX_IN_W,
   parameter int OUT_W  = EX_OUT_W
) (
   input  logic              CLK_EStage,
   input  logic              RST_EStage,
   input  logic [IN_W-1:0]   RegD,
   input  logic              StallE,
   input  logic              FlushE,
   input  logic              RegWriteM,
   input  logic [4:0]        WriteRegM,
   input  logic [DATA_W-1:0] ALUOutM,
   input  logic              RegWriteW,
   input  logic [4:0]        WriteRegW,
   input  logic [DATA_W-1:0] ResultW,
   output logic [OUT_W-1:0]  RegE,
   output logic              ZeroE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE
);

   logic [DATA_W-1:0] op1, op2, signImm, srcA, fwdB, srcB, aluResult;
   logic [4:0]        rs, rt, rd;
   logic [15:0]       imm;
   logic [2:0]        aluControl;
   logic              aluSrc, regDst, aluZero;
   logic [OUT_W-1:0]  nextE;

   assign op1        = RegD[D_OP1_LO +: DATA_W];
   assign op2        = RegD[D_OP2_LO +: DATA_W];
   assign rs         = RegD[D_RS_LO +: 5];
   assign rt         = RegD[D_RT_LO +: 5];
   assign rd         = RegD[D_RD_LO +: 5];
   assign imm        = RegD[D_IMM_LO +: 16];
   assign aluControl = RegD[D_ALUCTL_LO +: 3];
   assign aluSrc     = RegD[D_ALUSRC];
   assign regDst     = RegD[D_REGDST];
   assign signImm    = {{(DATA_W-16){imm[15]}}, imm};

   // Memory stage holds the newer value, so it wins over writeback; r0 never forwards.
   always_comb begin
      ForwardAE = FWD_NONE;
      ForwardBE = FWD_NONE;
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == rs))
         ForwardAE = FWD_MEM;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == rs))
         ForwardAE = FWD_WB;
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == rt))
         ForwardBE = FWD_MEM;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == rt))
         ForwardBE = FWD_WB;
   end

   always_comb begin
      case (ForwardAE)
         FWD_MEM: srcA = ALUOutM;
         FWD_WB:  srcA = ResultW;
         default: srcA = op1;
      endcase
      case (ForwardBE)
         FWD_MEM: fwdB = ALUOutM;
         FWD_WB:  fwdB = ResultW;
         default: fwdB = op2;
      endcase
   end

   assign srcB = aluSrc ? signImm : fwdB;

   alu_unit #(.DATA_W(DATA_W)) uAlu (
      .SrcA       (srcA),
      .SrcB       (srcB),
      .ALUControl (aluControl),
      .Result     (aluResult),
      .Zero       (aluZero)
   );

   assign ZeroE = aluZero;

   // Store data is the forwarded register value, never the immediate.
   always_comb begin
      nextE                          = '0;
      nextE[E_REGWRITE]              = RegD[D_REGWRITE];
      nextE[E_MEMTOREG]              = RegD[D_MEMTOREG];
      nextE[E_MEMWRITE]              = RegD[D_MEMWRITE];
      nextE[E_ALUOUT_LO +: DATA_W]   = aluResult;
      nextE[E_WDATA_LO +: DATA_W]    = fwdB;
      nextE[E_WREG_LO +: 5]          = regDst ? rd : rt;
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
   always_ff @(posedge CLK_EStage) begin
      if (RST_EStage)
         RegE <= '0;
      else if (FlushE)
         RegE <= '0;
      else if (!StallE)
         RegE <= nextE;
   end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed table, random vectors
// against a reference model, and stall/flush/reset sequences.
module tb_execute_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic [102:0] regD;
   logic         stallE, flushE;
   logic         rwM, rwW;
   logic [4:0]   wrM, wrW;
   logic [31:0]  aluM, resW;
   logic [71:0]  regE;
   logic         zeroE;
   logic [1:0]   fa, fb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .CLK_EStage (clk),
      .RST_EStage (rst),
      .RegD       (regD),
      .StallE     (stallE),
      .FlushE     (flushE),
      .RegWriteM  (rwM),
      .WriteRegM  (wrM),
      .ALUOutM    (aluM),
      .RegWriteW  (rwW),
      .WriteRegW  (wrW),
      .ResultW    (resW),
      .RegE       (regE),
      .ZeroE      (zeroE),
      .ForwardAE  (fa),
      .ForwardBE  (fb)
   );

   typedef struct {
      logic [102:0] d;
      logic         rM;
      logic [4:0]   wM;
      logic [31:0]  aM;
      logic         rW;
      logic [4:0]   wW;
      logic [31:0]  rsW;
      logic [71:0]  expE;
      logic [1:0]   expFa;
      logic [1:0]   expFb;
      logic         expZ;
   } vec_t;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [102:0] packD(input logic rw, input logic mtr, input logic mw,
         input logic [2:0] ctl, input logic asrc, input logic rdst, input logic [31:0] o1,
         input logic [31:0] o2, input logic [4:0] s, input logic [4:0] t, input logic [4:0] dd,
         input logic [15:0] im);
      return {rw, mtr, mw, ctl, asrc, rdst, o1, o2, s, t, dd, im};
   endfunction

   function automatic logic [71:0] packE(input logic rw, input logic mtr, input logic mw,
         input logic [31:0] r, input logic [31:0] wd, input logic [4:0] wr);
      return {rw, mtr, mw, r, wd, wr};
   endfunction

   // Reference model computed directly from the stage's architectural rules.
   function automatic void model(input logic [102:0] d, input logic rM, input logic [4:0] wM,
         input logic [31:0] aM, input logic rW, input logic [4:0] wW, input logic [31:0] rsW,
         output logic [71:0] e, output logic [1:0] xa, output logic [1:0] xb, output logic z);
      logic [4:0]  s, t;
      logic [31:0] a, b, bImm, r;
      int signed   sa, sb;
      s = d[30:26];
      t = d[25:21];
      xa = (rM && wM != 0 && wM == s) ? 2'd2 : (rW && wW != 0 && wW == s) ? 2'd1 : 2'd0;
      xb = (rM && wM != 0 && wM == t) ? 2'd2 : (rW && wW != 0 && wW == t) ? 2'd1 : 2'd0;
      a = (xa == 2) ? aM : (xa == 1) ? rsW : d[94:63];
      b = (xb == 2) ? aM : (xb == 1) ? rsW : d[62:31];
      bImm = d[96] ? {{16{d[15]}}, d[15:0]} : b;
      sa = a;
      sb = bImm;
      case (d[99:97])
         3'd2:    r = a + bImm;
         3'd6:    r = a - bImm;
         3'd0:    r = a & bImm;
         3'd1:    r = a | bImm;
         3'd7:    r = (sa < sb) ? 32'd1 : 32'd0;
         3'd5:    r = ~(a | bImm);
         default: r = 32'd0;
      endcase
      z = (r == 0);
      e = packE(d[102], d[101], d[100], r, b, d[95] ? d[20:16] : d[25:21]);
   endfunction

   task automatic setIn(input logic [102:0] d, input logic rM, input logic [4:0] wM,
         input logic [31:0] aM, input logic rW, input logic [4:0] wW, input logic [31:0] rsW);
      regD = d; rwM = rM; wrM = wM; aluM = aM; rwW = rW; wrW = wW; resW = rsW;
   endtask

   // Drive at negedge, check combinational outputs, then the registered word after the edge.
   task automatic applyVec(input string tag, input vec_t v);
      @(negedge clk);
      setIn(v.d, v.rM, v.wM, v.aM, v.rW, v.wW, v.rsW);
      #1;
      check({tag, " fwdA"}, 72'(fa), 72'(v.expFa));
      check({tag, " fwdB"}, 72'(fb), 72'(v.expFb));
      check({tag, " zero"}, 72'(zeroE), 72'(v.expZ));
      @(posedge clk);
      #1;
      check({tag, " regE"}, regE, v.expE);
   endtask

   function automatic vec_t modelVec(input logic [102:0] d, input logic rM, input logic [4:0] wM,
         input logic [31:0] aM, input logic rW, input logic [4:0] wW, input logic [31:0] rsW);
      vec_t v;
      v.d = d; v.rM = rM; v.wM = wM; v.aM = aM; v.rW = rW; v.wW = wW; v.rsW = rsW;
      model(d, rM, wM, aM, rW, wW, rsW, v.expE, v.expFa, v.expFb, v.expZ);
      return v;
   endfunction

   vec_t tbl[12];
   vec_t v;

   initial begin
      // Hand-computed directed vectors.
      tbl[0]  = '{packD(1,0,0,3'b010,0,1,32'd5,32'd3,5'd1,5'd2,5'd7,16'h0),
                  0,0,0, 0,0,0, packE(1,0,0,32'd8,32'd3,5'd7), 2'b00,2'b00,1'b0};
      tbl[1]  = '{packD(0,0,1,3'b010,1,0,32'd10,32'h55,5'd1,5'd3,5'd7,16'hFFFF),
                  0,0,0, 0,0,0, packE(0,0,1,32'd9,32'h55,5'd3), 2'b00,2'b00,1'b0};
      tbl[2]  = '{packD(0,0,1,3'b111,1,0,32'hFFFF_FFFE,32'h55,5'd1,5'd3,5'd7,16'hFFFF),
                  0,0,0, 0,0,0, packE(0,0,1,32'd1,32'h55,5'd3), 2'b00,2'b00,1'b0};
      tbl[3]  = '{packD(1,0,0,3'b010,0,0,32'd7,32'd0,5'd4,5'd5,5'd9,16'h0),
                  1,5'd4,32'd100, 1,5'd4,32'd50, packE(1,0,0,32'd100,32'd0,5'd5), 2'b10,2'b00,1'b0};
      tbl[4]  = '{packD(1,0,0,3'b010,0,0,32'd7,32'd0,5'd4,5'd5,5'd9,16'h0),
                  0,5'd4,32'd100, 1,5'd4,32'd50, packE(1,0,0,32'd50,32'd0,5'd5), 2'b01,2'b00,1'b0};
      tbl[5]  = '{packD(1,0,0,3'b010,0,0,32'd7,32'd0,5'd0,5'd5,5'd9,16'h0),
                  1,5'd0,32'd100, 1,5'd0,32'd50, packE(1,0,0,32'd7,32'd0,5'd5), 2'b00,2'b00,1'b0};
      tbl[6]  = '{packD(1,1,0,3'b110,0,1,32'd1,32'h99,5'd1,5'd6,5'd9,16'h0),
                  1,5'd6,32'h20, 0,0,0, packE(1,1,0,32'hFFFF_FFE1,32'h20,5'd9), 2'b00,2'b10,1'b0};
      tbl[7]  = '{packD(0,0,1,3'b000,1,0,32'h20,32'h99,5'd1,5'd6,5'd9,16'h0010),
                  0,5'd6,32'h20, 1,5'd6,32'h1234, packE(0,0,1,32'd0,32'h1234,5'd6), 2'b00,2'b01,1'b1};
      tbl[8]  = '{packD(1,0,0,3'b101,0,1,32'd0,32'd0,5'd1,5'd2,5'd3,16'h0),
                  0,0,0, 0,0,0, packE(1,0,0,32'hFFFF_FFFF,32'd0,5'd3), 2'b00,2'b00,1'b0};
      tbl[9]  = '{packD(1,0,0,3'b011,0,1,32'hAB,32'hCD,5'd1,5'd2,5'd3,16'h0),
                  0,0,0, 0,0,0, packE(1,0,0,32'd0,32'hCD,5'd3), 2'b00,2'b00,1'b1};
      tbl[10] = '{packD(1,0,0,3'b110,0,1,32'd0,32'd1,5'd1,5'd2,5'd4,16'h0),
                  0,0,0, 0,0,0, packE(1,0,0,32'hFFFF_FFFF,32'd1,5'd4), 2'b00,2'b00,1'b0};
      tbl[11] = '{packD(1,0,0,3'b111,0,1,32'h7FFF_FFFF,32'h8000_0000,5'd1,5'd2,5'd4,16'h0),
                  0,0,0, 0,0,0, packE(1,0,0,32'd0,32'h8000_0000,5'd4), 2'b00,2'b00,1'b1};

      rst = 1'b1; stallE = 1'b0; flushE = 1'b0;
      setIn('0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset state", regE, 72'd0);

      // Reset overrides a valid load.
      @(negedge clk);
      setIn(tbl[0].d, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("reset beats load", regE, 72'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         applyVec($sformatf("vec%0d", i), tbl[i]);

      for (int i = 0; i < 200; i++) begin
         logic [31:0] o1, o2;
         o1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         o2 = ($urandom_range(0, 3) == 0) ? o1 : $urandom;
         v = modelVec(packD(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                            1'($urandom), o1, o2, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom), 16'($urandom)),
                      1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom), 5'($urandom_range(0, 7)), $urandom);
         applyVec($sformatf("rand%0d", i), v);
      end

      // Stall holds the register while RegD changes, then flush wins over stall.
      applyVec("preStall", tbl[6]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stallE = 1'b1;
         regD = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk);
         #1;
         check($sformatf("stall hold %0d", i), regE, tbl[6].expE);
      end
      @(negedge clk);
      flushE = 1'b1;
      @(posedge clk);
      #1;
      check("flush during stall", regE, 72'd0);
      @(negedge clk);
      flushE = 1'b0; stallE = 1'b0;

      // Flush alone.
      applyVec("preFlush", tbl[0]);
      @(negedge clk);
      flushE = 1'b1;
      setIn(tbl[8].d, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("flush alone", regE, 72'd0);
      @(negedge clk);
      flushE = 1'b0;

      // Reset in the middle of a stall, then the first load one cycle after release.
      applyVec("preReset", tbl[1]);
      @(negedge clk);
      stallE = 1'b1;
      @(posedge clk);
      #1;
      check("stall before reset", regE, tbl[1].expE);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset mid-stall", regE, 72'd0);
      @(negedge clk);
      rst = 1'b0; stallE = 1'b0;
      setIn(tbl[10].d, 0, 0, 0, 0, 0, 0);
      #1;
      check("after reset release", regE, 72'd0);
      @(posedge clk);
      #1;
      check("first load after reset", regE, tbl[10].expE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter DATA_W, default 32; datapath width.
REQ-002 Parameter IN_W, default 103; width of the packed decode/execute word.
REQ-003 Parameter OUT_W, default 72; width of the packed execute/memory word.
REQ-004 CLK_EStage  input  1  single clock, rising edge.
REQ-005 RST_EStage  input  1  reset, synchronous and active-high.
REQ-006 RegD  input  IN_W  packed decode/execute word, field map below.
- [102] RegWrite; [101] MemtoReg; [100] MemWrite; [99:97] ALUControl; [96] ALUSrc; [95] RegDst.
- [94:63] Op1; [62:31] Op2; [30:26] Rs; [25:21] Rt; [20:16] Rd; [15:0] Imm.
REQ-007 StallE  input  1  hold the output register.
REQ-008 FlushE  input  1  clear the output register (bubble).
REQ-009 RegWriteM, WriteRegM[4:0], ALUOutM[31:0]  inputs  memory-stage forwarding source.
REQ-010 RegWriteW, WriteRegW[4:0], ResultW[31:0]  inputs  writeback-stage forwarding source.
REQ-011 RegE  output  OUT_W  packed execute/memory word, field map below.
- [71] RegWrite; [70] MemtoReg; [69] MemWrite.
- [68:37] ALUOut; [36:5] WriteData; [4:0] WriteReg.
REQ-012 ZeroE  output  1  combinational: the current ALU result equals 0.
REQ-013 ForwardAE, ForwardBE  outputs  2 each  combinational forwarding selects, for the hazard monitor.

Function
REQ-014 Field extraction from RegD shall be purely combinational, following the bit map in REQ-006.
REQ-015 SignImm shall be the 16-bit Imm sign-extended to DATA_W bits.
REQ-016 Forwarding select for operand A (ForwardAE):
- 2'b10 when RegWriteM=1, WriteRegM!=0 and WriteRegM==Rs.
- else 2'b01 when RegWriteW=1, WriteRegW!=0 and WriteRegW==Rs.
- else 2'b00.
REQ-017 ForwardBE shall follow the same rule as REQ-016, using Rt in place of Rs.
REQ-018 Operand selection:
- SrcA = Op1, ResultW or ALUOutM for ForwardAE 00, 01 or 10 respectively.
- The forwarded B value is selected the same way from Op2 using ForwardBE.
- SrcB = SignImm when ALUSrc=1, else the forwarded B value.
REQ-019 ALU operation by ALUControl:
- 010 = SrcA+SrcB; 110 = SrcA-SrcB; 000 = AND; 001 = OR.
- 111 = signed set-less-than, result 1 or 0.
- 011 and 100 = 0; 101 = SrcA NOR SrcB.
- Add/sub wrap modulo 2^32; no overflow flag.
REQ-020 WriteReg shall be Rd when RegDst=1, else Rt.
REQ-021 WriteData shall be the forwarded B value (not SrcB).
REQ-022 Output register update priority on each rising edge:
- Reset, then FlushE, then StallE, then load.
- Load writes {RegWrite, MemtoReg, MemWrite, ALUResult, WriteData, WriteReg}.
REQ-023 FlushE=1 shall load all-zero into RegE, including when StallE=1 in the same cycle.
REQ-024 StallE=1 with FlushE=0 shall leave RegE unchanged.
REQ-025 Latency: RegD to RegE is exactly one cycle when StallE=0 and FlushE=0.
REQ-026 Forwarding from register 0 shall never occur; Rs=0 always yields ForwardAE=00.

Reset
REQ-027 RST_EStage=1 at a rising edge shall set RegE to all-zero, overriding all other inputs.
REQ-028 Reset asserted mid-stall shall clear RegE; the held value shall not be retained.
REQ-029 The block has no internal state besides RegE.

Structure
REQ-030 A shared package shall hold:
- ALUControl encodings.
- Forward-select encodings.
- All field bit positions for both packed words.
- IN_W/OUT_W constants, shared with the decode register and the memory stage.
REQ-031 The ALU shall be a separate sub-module, alu_unit: SrcA, SrcB, ALUControl in; Result and Zero out.
REQ-032 Forwarding logic shall remain inline in execute_stage.

Verification
REQ-033 Op1=5, Op2=3, ALUControl=010, ALUSrc=0, RegDst=1, Rd=7, no forwarding:
- Next cycle ALUOut=8, WriteData=3, WriteReg=7.
REQ-034 Imm=16'hFFFF, ALUSrc=1, Op1=10, ALUControl=010:
- ALUOut=9.
- Repeat with ALUControl=111 and Op1=-2: ALUOut=1 (−2 < −1).
REQ-035 Rs=4 with RegWriteM=1, WriteRegM=4, ALUOutM=100 and RegWriteW=1, WriteRegW=4, ResultW=50:
- ForwardAE=10; SrcA=100.
- Clear RegWriteM: ForwardAE=01, SrcA=50.
- Set Rs=0: ForwardAE=00.
REQ-036 Load a nonzero word, then StallE=1 for 3 cycles while RegD changes:
- RegE is constant throughout the stall.
- With FlushE=1 and StallE=1 together: RegE=0 next cycle.
REQ-037 RST_EStage=1 during a StallE=1 hold:
- RegE=0 at the next edge.
- After reset drops, the first load appears one cycle later.
